memory_controller: RTL
======================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have ports: clk_in  in  1  sole clock; rst_in  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: rdy_in  in  1  global enable; clr_in  in  1  pipeline flush.
REQ-003 SHALL have RAM ports: mem_din  in  8  read byte; mem_dout  out  8  write byte; mem_a  out  32  byte address; mem_wr  out  1  write strobe; io_buffer_full  in  1  UART FIFO full.
REQ-004 SHALL have fetch ports: if_to_mc_ready  in  1  fetch request, level-held; if_to_mc_PC  in  32  fetch address; mc_to_if_ready  out  1  response pulse; mc_to_if_inst  out  32  fetched word.
REQ-005 SHALL have LSB ports: lsb_to_mc_ready  in  1  request, level-held; lsb_to_mc_wr  in  1  1=store; lsb_to_mc_addr  in  32; lsb_to_mc_len  in  2  00 byte/01 half/10 word; lsb_to_mc_data  in  32  store data; mc_to_lsb_ready  out  1  response pulse; mc_to_lsb_data  out  32  load data.

Function
REQ-006 SHALL use states IDLE, IF_READ, LS_READ, LS_WRITE plus a 3-bit byte counter.
REQ-007 In IDLE, SHALL accept a request only when mc_to_if_ready and mc_to_lsb_ready are both low (no re-accept on response cycle).
REQ-008 On simultaneous requests, SHALL serve LSB first; IF waits.
REQ-009 Accept edge E0: mem_a <= request address, counter <= 0; N = 4 for IF, 1/2/4 per lsb_to_mc_len.
REQ-010 Read: mem_a at edge Ek = addr+k for k<N; byte k (from mem_din) captured at edge E(k+2); result little-endian, zero-extended above N bytes.
REQ-011 Read completes at E(N+1): response pulse high for exactly the following cycle with data valid; state -> IDLE; word fetch latency 5 cycles.
REQ-012 Write: during cycle after Ek (k<N), mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k]; at EN mem_wr<=0, mc_to_lsb_ready<=1 for one cycle, state -> IDLE.
REQ-013 In IDLE and outside active write cycles, mem_wr SHALL be 0 and mem_a SHALL be 0.
REQ-014 clr_in high at an edge SHALL abort IF_READ and LS_READ (-> IDLE, no response pulse, pulses cleared); LS_WRITE SHALL complete unaffected.
REQ-015 rdy_in low SHALL freeze state, counter and registered outputs; mem_wr SHALL read 0 while rdy_in low.
REQ-016 Address increment SHALL wrap modulo 2^32.
REQ-017 Request inputs SHALL be sampled only at the accept edge; later changes ignored until IDLE.

Reset
REQ-018 rst_in high SHALL asynchronously force IDLE, counter 0, mem_a 0, mem_dout 0, mem_wr 0, both response pulses 0, both data outputs 0.
REQ-019 Reset mid-transaction SHALL discard it; no response after reset release.
REQ-020 rst_in SHALL take priority over rdy_in and clr_in.

Configuration
REQ-021 Macro IO_BUFFER_GUARD_EN defined: store with addr[17:16]==2'b11 SHALL NOT be accepted while io_buffer_full is high; IF requests may be served meanwhile.
REQ-022 Macro IO_BUFFER_GUARD_EN undefined: io_buffer_full ignored; all stores accepted per REQ-007/008.

Verification
REQ-023 IF fetch PC=0x00000010, RAM bytes 0x13,0x05,0x00,0x00 -> mc_to_if_inst=0x00000513, one-cycle pulse 5 cycles after accept, mem_wr never high.
REQ-024 IF and LSB byte store (addr 0x1000, data 0xAB) requested same cycle -> single write cycle mem_a=0x1000 mem_dout=0xAB, then IF fetch starts, ≥1 IDLE cycle between.
REQ-025 Half load addr 0x2002, bytes 0x34,0x12 -> mc_to_lsb_data=0x00001234 after 3 cycles.
REQ-026 clr_in during IF_READ counter 2 -> IDLE next cycle, no mc_to_if_ready; clr_in during word store -> all 4 bytes written.
REQ-027 IO_BUFFER_GUARD_EN, store to 0x30000 with io_buffer_full=1 for 10 cycles -> no mem_wr until full drops, then one byte written.
REQ-028 rst_in asserted mid word-load between edges -> outputs zero immediately, no response pulse after release.

Source files
------------

// File: rtl/memory_controller_if.sv
// Bus bundle between the memory controller, the RAM/UART port, the fetch unit
// and the load/store buffer.
//   RAM   : mem_din (rd byte), mem_dout (wr byte), mem_a (byte addr),
//           mem_wr (write strobe), io_buffer_full (UART FIFO full)
//   Fetch : if_to_mc_ready/if_to_mc_PC request, mc_to_if_ready/mc_to_if_inst response
//   LSB   : lsb_to_mc_* request, mc_to_lsb_ready/mc_to_lsb_data response
// slave  = controller side, master = requesters/RAM side.
interface memory_controller_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic        if_to_mc_ready;
    logic [31:0] if_to_mc_PC;
    logic        mc_to_if_ready;
    logic [31:0] mc_to_if_inst;

    logic        lsb_to_mc_ready;
    logic        lsb_to_mc_wr;
    logic [31:0] lsb_to_mc_addr;
    logic [1:0]  lsb_to_mc_len;
    logic [31:0] lsb_to_mc_data;
    logic        mc_to_lsb_ready;
    logic [31:0] mc_to_lsb_data;

    modport slave (
        input  mem_din, io_buffer_full,
        input  if_to_mc_ready, if_to_mc_PC,
        input  lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
        output mem_dout, mem_a, mem_wr,
        output mc_to_if_ready, mc_to_if_inst,
        output mc_to_lsb_ready, mc_to_lsb_data
    );

    modport master (
        output mem_din, io_buffer_full,
        output if_to_mc_ready, if_to_mc_PC,
        output lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
        input  mem_dout, mem_a, mem_wr,
        input  mc_to_if_ready, mc_to_if_inst,
        input  mc_to_lsb_ready, mc_to_lsb_data
    );
endinterface

// File: rtl/memory_controller.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// traffic onto an 8-bit RAM port with one cycle of read latency.
// Ports:
//   clk_in  - clock
//   rst_in  - asynchronous active-high reset
//   rdy_in  - global enable; low freezes all state (mem_wr forced low)
//   clr_in  - pipeline flush; aborts reads, stores always complete
//   bus     - memory_controller_if.slave (RAM, fetch and LSB channels)
// Optional feature: define IO_BUFFER_GUARD_EN to hold off stores to the
// UART region (addr[17:16] == 2'b11) while io_buffer_full is high.
module memory_controller (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clr_in,
    memory_controller_if.slave bus
);
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rbuf_q, rbuf_d;
    logic [AW-1:0]    mem_a_q, mem_a_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic             mem_wr_q, mem_wr_d;
    logic             if_rdy_q, if_rdy_d;
    logic [DW-1:0]    if_inst_q, if_inst_d;
    logic             lsb_rdy_q, lsb_rdy_d;
    logic [DW-1:0]    lsb_data_q, lsb_data_d;

    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] lsb_n;
    logic [1:0]       bidx;
    logic [1:0]       wsel;
    logic             lsb_block;

    // Stores into the UART window wait while its FIFO is full.
`ifdef IO_BUFFER_GUARD_EN
    assign lsb_block = bus.lsb_to_mc_wr && (bus.lsb_to_mc_addr[17:16] == 2'b11)
                       && bus.io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = bus.io_buffer_full;
    assign lsb_block      = 1'b0;
`endif

    // Transfer length in bytes for an LSB request.
    always_comb begin
        case (bus.lsb_to_mc_len)
            2'b00:   lsb_n = CNT_W'(1);
            2'b01:   lsb_n = CNT_W'(2);
            default: lsb_n = CNT_W'(4);
        endcase
    end

    // Next-state and next-output logic. step is the index k of the edge being
    // evaluated; read byte k-2 arrives on mem_din one cycle after its address.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_rdy_d   = 1'b0;
        if_inst_d  = if_inst_q;
        lsb_rdy_d  = 1'b0;
        lsb_data_d = lsb_data_q;
        step       = cnt_q + CNT_W'(1);
        bidx       = 2'(step - CNT_W'(2));
        wsel       = 2'(step);

        case (state_q)
            IDLE: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
                // No accept in a response cycle so a held request is not served twice.
                if (!if_rdy_q && !lsb_rdy_q) begin
                    if (bus.lsb_to_mc_ready && !lsb_block) begin
                        cnt_d   = '0;
                        len_d   = lsb_n;
                        mem_a_d = bus.lsb_to_mc_addr;
                        rbuf_d  = '0;
                        wdata_d = bus.lsb_to_mc_data;
                        if (bus.lsb_to_mc_wr) begin
                            state_d    = LS_WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.lsb_to_mc_data[7:0];
                        end else begin
                            state_d = LS_READ;
                        end
                    end else if (bus.if_to_mc_ready) begin
                        state_d = IF_READ;
                        cnt_d   = '0;
                        len_d   = CNT_W'(4);
                        mem_a_d = bus.if_to_mc_PC;
                        rbuf_d  = '0;
                    end
                end
            end

            IF_READ, LS_READ: begin
                if (clr_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    mem_a_d = '0;
                end else begin
                    cnt_d = step;
                    if (step < len_q) mem_a_d = mem_a_q + AW'(1);
                    if (step >= CNT_W'(2)) rbuf_d[{bidx, 3'b000} +: 8] = bus.mem_din;
                    if (step == len_q + CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        mem_a_d = '0;
                        if (state_q == IF_READ) begin
                            if_rdy_d  = 1'b1;
                            if_inst_d = rbuf_d;
                        end else begin
                            lsb_rdy_d  = 1'b1;
                            lsb_data_d = rbuf_d;
                        end
                    end
                end
            end

            LS_WRITE: begin
                cnt_d = step;
                if (step < len_q) begin
                    mem_a_d    = mem_a_q + AW'(1);
                    mem_dout_d = wdata_q[{wsel, 3'b000} +: 8];
                end else begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_a_d   = '0;
                    mem_wr_d  = 1'b0;
                    lsb_rdy_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; rdy_in low holds everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_rdy_q   <= 1'b0;
            if_inst_q  <= '0;
            lsb_rdy_q  <= 1'b0;
            lsb_data_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_rdy_q   <= if_rdy_d;
            if_inst_q  <= if_inst_d;
            lsb_rdy_q  <= lsb_rdy_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    assign bus.mem_a           = mem_a_q;
    assign bus.mem_dout        = mem_dout_q;
    assign bus.mem_wr          = mem_wr_q & rdy_in;
    assign bus.mc_to_if_ready  = if_rdy_q;
    assign bus.mc_to_if_inst   = if_inst_q;
    assign bus.mc_to_lsb_ready = lsb_rdy_q;
    assign bus.mc_to_lsb_data  = lsb_data_q;
endmodule
